tri_state_bus_arbiter: RTL and testbench
========================================

// Module: tri_state_bus_arbiter
// PURPOSE
//   Round-robin arbiter for a shared tri-state bus driven by N_REQ tri_state_buffer instances.
//   enable[i] drives the enable input of buffer i, so at most one buffer drives the bus at a time.
//   Forces an idle turnaround gap between owners so two drivers never overlap.
//   Forces release after MAX_HOLD cycles so no requester can starve the others.
// PARAMETERS
//   N_REQ       4  number of requesters / tri-state drivers (>=2)
//   MAX_HOLD    8  max consecutive OWNED cycles per grant (>=1)
//   TURNAROUND  1  idle cycles, all enables low, between owners (>=1)
// PORTS
//   clk       in   1                    single clock, rising edge
//   reset     in   1                    synchronous, active-high
//   req       in   N_REQ                level requests, one bit per driver
//   grant     out  N_REQ                one-hot current owner, 0 when bus not owned
//   enable    out  N_REQ                tri-state drive enables, identical to grant
//   owner     out  $clog2(N_REQ)        index of last/current owner
//   bus_busy  out  1                    high in OWNED and GAP states
// BEHAVIOUR
//   Clocking and reset
//   - One clock. Reset is synchronous and active-high. All outputs are registered.
//   - Reset value: state=IDLE, grant=0, enable=0, owner=N_REQ-1, bus_busy=0, hold_cnt=0.
//   - owner=N_REQ-1 at reset makes req[0] the highest priority first.
//   States
//   - IDLE: any req -> OWNED on the next edge; grant/enable rise one cycle after req is sampled.
//   - IDLE: no req -> stay in IDLE.
//   - OWNED: hold_cnt counts owned cycles, starting at 1 in the first owned cycle.
//   - OWNED: stay while req[owner]=1 and hold_cnt<MAX_HOLD.
//   - OWNED: exit to GAP when req[owner]=0, or when hold_cnt==MAX_HOLD.
//     Enable is therefore high for at least 1 and at most MAX_HOLD cycles.
//   - GAP: grant=enable=0 for exactly TURNAROUND cycles; gap counter width is $clog2(TURNAROUND+1).
//   - GAP, last cycle: arbitrate on that cycle's req. Any req -> OWNED with the winner; none -> IDLE.
//   Arbitration
//   - Winner is the first set req bit scanning owner+1, owner+2, ... modulo N_REQ.
//   - owner updates when a grant is issued.
//   - A requester released by timeout with req still high stays eligible, but has lowest priority.
//   - A lone requester released by timeout is re-granted after the gap.
//   Boundary cases
//   - req changes during GAP before the last cycle are ignored; only last-cycle sampling counts.
//   - A grantee that drops req in its first owned cycle still owns for exactly 1 cycle.
//   - Requests from non-owners during OWNED do not preempt the owner.
//   - Reset mid-ownership: enable=0 at the edge that samples reset high; full reset values follow.
//   - Invariants, every cycle:
//     - $onehot0(enable);
//     - enable==grant;
//     - enable never changes directly from one nonzero value to a different nonzero value.
//   - hold_cnt width is $clog2(MAX_HOLD+1) and saturates; it never wraps.
// TESTING
//   1 Reset 2 cycles with req=4'b1111 -> enable=0, bus_busy=0 throughout; enable=4'b0001 one cycle after reset drops.
//   2 From IDLE req=4'b0100 at cycle 0, dropped at cycle 5 -> enable=4'b0100 on cycles 1-5, 0 at cycle 6; bus_busy low at cycle 7.
//   3 req=4'b1111 held, MAX_HOLD=8 -> owners 0,1,2,3,0, each with 8 enable cycles, separated by one all-zero cycle.
//   4 req0 owned; req0 falls as req2 rises -> enable 0001 -> 0000 (1 cycle) -> 0100; $onehot0 checked every cycle.
//   5 Lone req=4'b0010 held for 20 cycles, MAX_HOLD=8 -> enable 0010 x8, gap, 0010 x8, gap, repeat.
//   6 Reset while enable=4'b0010, then req=4'b0011 -> enable=0 the next edge; after reset the grant goes to req0, not req1.

Source files
------------

// File: rtl/tri_state_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus: one-hot drive enables, a forced idle
// turnaround gap between owners, and a hold limit so no requester can starve the others.
module tri_state_bus_arbiter #(
    parameter int N_REQ      = 4,
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         enable,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     bus_busy
);

    localparam int OW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int GW = $clog2(TURNAROUND + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD);
    localparam logic [GW-1:0] GAP_LAST  = GW'(TURNAROUND);
    localparam logic [OW-1:0] OWNER_RST = OW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [N_REQ-1:0] grant_d;
    logic [OW-1:0]    owner_d;
    logic [HW-1:0]    hold_cnt, hold_cnt_d;
    logic [GW-1:0]    gap_cnt, gap_cnt_d;
    logic             bus_busy_d;
    logic             win_found;
    logic [OW-1:0]    win_idx;

    // Scan owner+1, owner+2, ... so the previous owner is considered last.
    function automatic logic [OW:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [OW-1:0]    last);
        logic          found;
        logic [OW-1:0] idx;
        logic [OW-1:0] win;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = OW'((int'(last) + k) % N_REQ);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    // NOTE: every variable written here gets its default first, so no path can infer a latch.
    always_comb begin
        state_d    = state;
        grant_d    = grant;
        owner_d    = owner;
        hold_cnt_d = hold_cnt;
        gap_cnt_d  = gap_cnt;
        bus_busy_d = bus_busy;
        {win_found, win_idx} = rr_pick(req, owner);

        case (state)
            IDLE: begin
                if (win_found) begin
                    state_d    = OWNED;
                    grant_d    = N_REQ'(1) << win_idx;
                    owner_d    = win_idx;
                    hold_cnt_d = HW'(1);
                    bus_busy_d = 1'b1;
                end
            end

            OWNED: begin
                // hold_cnt only advances below the limit, so it saturates rather than wraps.
                if (req[owner] && (hold_cnt < HOLD_LAST)) begin
                    hold_cnt_d = hold_cnt + 1'b1;
                end else begin
                    state_d    = GAP;
                    grant_d    = '0;
                    hold_cnt_d = '0;
                    gap_cnt_d  = GW'(1);
                end
            end

            GAP: begin
                // Only the final turnaround cycle's requests take part in arbitration.
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_d = '0;
                    if (win_found) begin
                        state_d    = OWNED;
                        grant_d    = N_REQ'(1) << win_idx;
                        owner_d    = win_idx;
                        hold_cnt_d = HW'(1);
                    end else begin
                        state_d    = IDLE;
                        bus_busy_d = 1'b0;
                    end
                end else begin
                    gap_cnt_d = gap_cnt + 1'b1;
                end
            end

            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                hold_cnt_d = '0;
                gap_cnt_d  = '0;
                bus_busy_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= OWNER_RST;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            bus_busy <= 1'b0;
        end else begin
            state    <= state_d;
            grant    <= grant_d;
            owner    <= owner_d;
            hold_cnt <= hold_cnt_d;
            gap_cnt  <= gap_cnt_d;
            bus_busy <= bus_busy_d;
        end
    end

    assign enable = grant;

endmodule

// File: tb/tb_tri_state_bus_arbiter.sv
// Scoreboard bench for tri_state_bus_arbiter: directed per-cycle vectors push expected
// enable/bus_busy/owner; a monitor pops and compares, and checks bus invariants each cycle.
module tb_tri_state_bus_arbiter;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic [3:0] grant;
    logic [3:0] enable;
    logic [1:0] owner;
    logic       bus_busy;

    typedef struct {
        logic [3:0] en;
        logic       busy;
        logic [1:0] own;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    logic [3:0] prev_en = 4'b0000;

    always #5 clk = ~clk;

    tri_state_bus_arbiter #(
        .N_REQ      (4),
        .MAX_HOLD   (8),
        .TURNAROUND (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .enable   (enable),
        .owner    (owner),
        .bus_busy (bus_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the next rising edge.
    task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] en,
                        input logic busy, input logic [1:0] own, input string tag);
        exp_t e;
        @(negedge clk);
        reset = rst;
        req   = r;
        e.en   = en;
        e.busy = busy;
        e.own  = own;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Monitor: compares one queued expectation per cycle, plus the bus invariants.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, " enable"}, 32'(enable), 32'(e.en));
                check({e.tag, " bus_busy"}, 32'(bus_busy), 32'(e.busy));
                check({e.tag, " owner"}, 32'(owner), 32'(e.own));
                check({e.tag, " grant==enable"}, 32'(grant), 32'(enable));
                check({e.tag, " onehot0"}, 32'($onehot0(enable)), 32'd1);
                if (prev_en != 4'b0000 && enable != 4'b0000)
                    check({e.tag, " direct handover"}, 32'(enable), 32'(prev_en));
                prev_en = enable;
            end
        end
    end

    initial begin
        int o;

        // Reset with all requests pending, then full round robin with timeouts.
        step(1'b1, 4'b1111, 4'b0000, 1'b0, 2'd3, "rst1");
        step(1'b1, 4'b1111, 4'b0000, 1'b0, 2'd3, "rst2");
        for (int r = 0; r < 5; r++) begin
            o = r % 4;
            for (int j = 0; j < 8; j++)
                step(1'b0, 4'b1111, 4'b0001 << o, 1'b1, 2'(o), "rr_own");
            step(1'b0, 4'b1111, 4'b0000, 1'b1, 2'(o), "rr_gap");
        end

        // Owner 0 releases as requester 2 rises: one idle cycle between them.
        step(1'b1, 4'b0000, 4'b0000, 1'b0, 2'd3, "ho_rst");
        step(1'b0, 4'b0001, 4'b0001, 1'b1, 2'd0, "ho_own0");
        step(1'b0, 4'b0001, 4'b0001, 1'b1, 2'd0, "ho_own0");
        step(1'b0, 4'b0100, 4'b0000, 1'b1, 2'd0, "ho_gap");
        step(1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, "ho_own2");
        step(1'b0, 4'b0000, 4'b0000, 1'b1, 2'd2, "ho_gap2");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, "ho_idle");

        // Request from IDLE held five cycles, then dropped.
        for (int j = 0; j < 5; j++)
            step(1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, "lvl_own");
        step(1'b0, 4'b0000, 4'b0000, 1'b1, 2'd2, "lvl_gap");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, "lvl_idle");

        // Lone requester held: re-granted after each timeout gap.
        for (int i = 0; i < 20; i++)
            step(1'b0, 4'b0010, ((i % 9) == 8) ? 4'b0000 : 4'b0010, 1'b1, 2'd1, "lone");

        // Reset mid-ownership; afterwards req0 wins, and req1 cannot preempt it.
        step(1'b1, 4'b0011, 4'b0000, 1'b0, 2'd3, "mid_rst");
        step(1'b0, 4'b0011, 4'b0001, 1'b1, 2'd0, "post_rst");
        step(1'b0, 4'b0011, 4'b0001, 1'b1, 2'd0, "no_preempt");
        step(1'b0, 4'b0011, 4'b0001, 1'b1, 2'd0, "no_preempt");
        step(1'b0, 4'b0010, 4'b0000, 1'b1, 2'd0, "pr_gap");
        step(1'b0, 4'b0010, 4'b0010, 1'b1, 2'd1, "pr_own1");
        step(1'b0, 4'b0000, 4'b0000, 1'b1, 2'd1, "pr_gap2");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1, "pr_idle");

        // Grantee drops its request in the first owned cycle: owns exactly one cycle.
        step(1'b0, 4'b1000, 4'b1000, 1'b1, 2'd3, "one_own");
        step(1'b0, 4'b0000, 4'b0000, 1'b1, 2'd3, "one_gap");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 2'd3, "one_idle");

        for (int w = 0; w < 10; w++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0)
            check("scoreboard drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
